// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the 6-digit stopwatch datapath.
//   Synchronises (and optionally debounces) the three active-low keys into press events,
//   runs the IDLE/RUN/PAUSE/LAP FSM, and drives the datapath's clear pulse, 10 ms count
//   tick and display-load enable. The BCD counters and display latches live elsewhere.
//
// Build option: define KEY_DEBOUNCE_EN to build the per-key debounce filter. Without it the
//   debounced level is the synchroniser output and DEBOUNCE is ignored.
//
// Parameters:
//   TICK_DIV     clk cycles per count_tick (>= 2)
//   DEBOUNCE     cycles a synced key must be stable before its debounced level moves (>= 1)
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   key_reset_n  raw reset key, 0 = pressed, asynchronous
//   key_start_n  raw start/pause key, 0 = pressed, asynchronous
//   key_lap_n    raw lap key, 0 = pressed, asynchronous
//   clear        1-cycle pulse: zero all BCD counters
//   count_tick   1-cycle pulse: advance the BCD counter chain by one 10 ms step
//   display_load 1 = display registers follow counters, 0 = display frozen (LAP)
//   state        FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_reset_n,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    output logic       clear,
    output logic       count_tick,
    output logic       display_load,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StLap   = 2'b11
    } state_e;

    localparam int unsigned PresW = $clog2(TICK_DIV);

    // Key bit order: 0 reset, 1 start, 2 lap.
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] level;
    logic [2:0] level_prev_q;
    logic [2:0] press;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            level_prev_q <= '1;
        end else begin
            sync1_q      <= {key_lap_n, key_start_n, key_reset_n};
            sync2_q      <= sync1_q;
            level_prev_q <= level;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DbW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [DbW-1:0] db_cnt_q [3];
    logic [2:0]     level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '1;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbW'(DEBOUNCE - 1)) begin
                    level_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;

    // DEBOUNCE has no effect in this build; this empty scope only marks an illegal value.
    if (DEBOUNCE == 0) begin : g_illegal_debounce
    end
`endif

    // Press = debounced falling edge; releases produce nothing.
    assign press = level_prev_q & ~level;

    state_e           state_q, state_d;
    logic [PresW-1:0] presc_q, presc_d;
    logic             clear_q, clear_d;
    logic             tick_q, tick_d;
    logic             dl_q, dl_d;
    logic             run_now, run_next, wrap;

    always_comb begin
        state_d = state_q;
        if (press[0]) begin
            state_d = StIdle;
        end else if (press[1]) begin
            unique case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                StLap:   state_d = StPause;
            endcase
        end else if (press[2]) begin
            unique case (state_q)
                StRun:   state_d = StLap;
                StLap:   state_d = StRun;
                default: state_d = state_q;
            endcase
        end
    end

    assign run_now  = (state_q == StRun) || (state_q == StLap);
    assign run_next = (state_d == StRun) || (state_d == StLap);
    assign wrap     = (presc_q == PresW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q;
        clear_d = 1'b0;
        tick_d  = 1'b0;
        dl_d    = (state_d != StLap);
        if (press[0]) begin
            presc_d = '0;
            clear_d = 1'b1;
        end else if (run_now) begin
            if (!wrap) begin
                presc_d = presc_q + 1'b1;
            end else if (run_next) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end
            // Wrap on a pause edge: hold at TICK_DIV-1 so the tick lands right after resume.
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            clear_q <= 1'b0;
            tick_q  <= 1'b0;
            dl_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            clear_q <= clear_d;
            tick_q  <= tick_d;
            dl_q    <= dl_d;
        end
    end

    assign clear        = clear_q;
    assign count_tick   = tick_q;
    assign display_load = dl_q;
    assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=5, DEBOUNCE=4. Expected state changes, ticks and
// clear pulses are queued (ordered by cycle) when keys are driven; a negedge monitor pops
// and compares every output event the DUT produces.
module tb_stopwatch_ctrl;

    localparam int TickDiv  = 5;
    localparam int Debounce = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int Lat = 2 + Debounce + 1;
`else
    localparam int Lat = 3;
`endif

    localparam logic [1:0] SIdle  = 2'b00;
    localparam logic [1:0] SRun   = 2'b01;
    localparam logic [1:0] SPause = 2'b10;
    localparam logic [1:0] SLap   = 2'b11;
    localparam int CodeTick  = 4;
    localparam int CodeClear = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_reset_n = 1'b1;
    logic       key_start_n = 1'b1;
    logic       key_lap_n = 1'b1;
    logic       clear;
    logic       count_tick;
    logic       display_load;
    logic [1:0] state;

    stopwatch_ctrl #(
        .TICK_DIV(TickDiv),
        .DEBOUNCE(Debounce)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_reset_n (key_reset_n),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .clear       (clear),
        .count_tick  (count_tick),
        .display_load(display_load),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard entries: cycle*8 + code (code 0..3 = new state, 4 = tick, 5 = clear).
    int exp_q[$];

    task automatic sb_push(input int at, input int code);
        int key;
        int i;
        key = at * 8 + code;
        i = 0;
        while (i < exp_q.size() && exp_q[i] <= key) i++;
        exp_q.insert(i, key);
    endtask

    task automatic observe(input logic [31:0] code);
        logic [31:0] key;
        key = cyc * 8 + code;
        if (exp_q.size() == 0) begin
            check_eq($sformatf("unexpected event (cycle*8+code) at cycle %0d", cyc), key,
                     32'hFFFF_FFFF);
        end else begin
            check_eq($sformatf("event (cycle*8+code) at cycle %0d", cyc), key, exp_q.pop_front());
        end
    endtask

    logic [1:0] prev_state = SIdle;
    bit         mon_en = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (state !== prev_state) begin
                    observe({30'b0, state});
                    prev_state = state;
                end
                if (count_tick !== 1'b0) observe(CodeTick);
                if (clear !== 1'b0) observe(CodeClear);
            end
        end
    end

    // Reference model of the stopwatch, advanced at key-press granularity.
    logic [1:0] m_state = SIdle;
    int         next_tick = 0;
    int         paused_p = 0;

    function automatic bit is_running(input logic [1:0] s);
        return (s == SRun) || (s == SLap);
    endfunction

    function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic [2:0] m);
        if (m[2]) return SIdle;
        if (m[1]) begin
            case (s)
                SIdle:   return SRun;
                SRun:    return SPause;
                SPause:  return SRun;
                default: return SPause;
            endcase
        end
        if (m[0]) begin
            if (s == SRun) return SLap;
            if (s == SLap) return SRun;
        end
        return s;
    endfunction

    task automatic push_ticks(input int upto);
        if (is_running(m_state)) begin
            while (next_tick <= upto) begin
                sb_push(next_tick, CodeTick);
                next_tick += TickDiv;
            end
        end
    endtask

    // Events with mask m {reset,start,lap} take effect (state visible) at cycle e.
    task automatic plan(input int e, input logic [2:0] m);
        logic [1:0] ns;
        int d;
        ns = fsm_next(m_state, m);
        if (is_running(m_state) && is_running(ns)) begin
            push_ticks(e);
        end else if (is_running(m_state)) begin
            push_ticks(e - 1);
            d = e - (next_tick - TickDiv);
            paused_p = (d >= TickDiv) ? TickDiv - 1 : d;
        end else if (is_running(ns)) begin
            next_tick = (m_state == SPause) ? e + TickDiv - paused_p : e + TickDiv;
        end
        if (m[2]) sb_push(e, CodeClear);
        if (ns != m_state) sb_push(e, int'(ns));
        m_state = ns;
    endtask

    task automatic idle(input int n);
        push_ticks(cyc + n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_keys(input logic [2:0] m);
        key_reset_n = ~m[2];
        key_start_n = ~m[1];
        key_lap_n   = ~m[0];
    endtask

    task automatic press(input logic [2:0] m);
        drive_keys(m);
        plan(cyc + Lat, m);
        idle(10);
        drive_keys(3'b000);
        idle(8);
    endtask

    task automatic check_levels(input string tag);
        check_eq({tag, " state"}, state, m_state);
        check_eq({tag, " display_load"}, display_load, m_state != SLap);
    endtask

    task automatic bounce_start();
        key_start_n = 1'b0;
`ifndef KEY_DEBOUNCE_EN
        plan(cyc + Lat, 3'b010);
`endif
        idle(2);
        key_start_n = 1'b1;
        idle(2);
        key_start_n = 1'b0;
        plan(cyc + Lat, 3'b010);
        idle(10);
        key_start_n = 1'b1;
        idle(8);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("reset state", state, SIdle);
        check_eq("reset display_load", display_load, 1'b1);
        check_eq("reset clear", clear, 1'b0);
        check_eq("reset count_tick", count_tick, 1'b0);
        prev_state = SIdle;
        mon_en = 1'b1;

        // Idle with keys released.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_levels("idle");
        end

        // Start -> RUN, ticks every TickDiv cycles.
        press(3'b010);
        check_levels("run");
        idle(10);

        // Lap freezes the display, counting continues; lap again resumes.
        press(3'b001);
        check_levels("lap");
        idle(12);
        press(3'b001);
        check_levels("lap exit");
        idle(4);

        // Pause with the prescaler at 2, hold 50 cycles, resume.
        while (((((cyc + Lat - next_tick) % TickDiv) + TickDiv) % TickDiv) != 2) idle(1);
        press(3'b010);
        check_levels("pause");
        idle(50);
        press(3'b010);
        check_levels("resume");
        idle(10);

        // Lap then start: LAP -> PAUSE releases the display.
        press(3'b001);
        press(3'b010);
        check_levels("lap to pause");
        press(3'b010);
        idle(6);

        // Bouncing start key.
        bounce_start();
        check_levels("bounce");

        // Reset and start keys together from RUN: reset wins.
        if (m_state != SRun) press(3'b010);
        idle(7);
        press(3'b110);
        check_levels("reset key");
        idle(10);

        // Synchronous reset in the middle of a lap debounce.
        press(3'b010);
        idle(3);
        key_lap_n = 1'b0;
        idle(2);
        #1;
        mon_en = 1'b0;
        check_eq("queue drained before reset", exp_q.size(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_state = SIdle;
        prev_state = SIdle;
        mon_en = 1'b1;
        check_eq("sync reset state", state, SIdle);
        check_eq("sync reset clear", clear, 1'b0);
        check_eq("sync reset display_load", display_load, 1'b1);
        idle(20);
        key_lap_n = 1'b1;
        idle(10);
        check_levels("after sync reset");

        check_eq("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
